// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op and state
// encodings plus the default latencies.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } md_state_e;

    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;
    localparam int DEF_CNT_W   = 4;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Pipeline-side bundle of the multiply/divide unit: E-stage requests,
// D-stage usage hint, and the busy/stall/HI/LO results.
interface muldiv_ctrl_if;

    logic        start_E;
    logic [1:0]  op_E;
    logic        mthi_E;
    logic        mtlo_E;
    logic [31:0] srca_E;
    logic [31:0] srcb_E;
    logic        md_use_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start_E, op_E, mthi_E, mtlo_E, srca_E, srcb_E, md_use_D,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  start_E, op_E, mthi_E, mtlo_E, srca_E, srcb_E, md_use_D,
        output busy, md_stall, hi, lo
    );

endinterface

// File: rtl/muldiv_ctrl_arith.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu, including
// the MIPS-style divide-by-zero and signed-overflow results.
module muldiv_arith
    import muldiv_ctrl_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic signed [63:0] sa_ext;
    logic signed [63:0] sb_ext;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic               div_zero;
    logic               div_ovf;

    assign sa_ext   = {{32{a[31]}}, a};
    assign sb_ext   = {{32{b[31]}}, b};
    assign div_zero = (b == 32'h0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Divider inputs are steered to safe values on the special cases so the
    // raw operators never see a zero divisor or the overflowing pair.
    always_comb begin
        sq = 32'sd0;
        sr = 32'sd0;
        uq = 32'h0;
        ur = 32'h0;
        if (!div_zero && !div_ovf) begin
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
        end
        if (!div_zero) begin
            uq = a / b;
            ur = a % b;
        end
    end

    always_comb begin
        result = 64'h0;
        case (op)
            MD_MULT:  result = sa_ext * sb_ext;
            MD_MULTU: result = {32'h0, a} * {32'h0, b};
            MD_DIV: begin
                if (div_zero)
                    result = {a, 32'hFFFF_FFFF};
                else if (div_ovf)
                    result = {32'h0, 32'h8000_0000};
                else
                    result = {sr, sq};
            end
            MD_DIVU: begin
                if (div_zero)
                    result = {a, 32'hFFFF_FFFF};
                else
                    result = {ur, uq};
            end
            default:  result = 64'h0;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: accepts an op from E, holds the result for a
// fixed latency, commits it to HI/LO, and raises a stall for D-stage users.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_ctrl_if.slave  bus
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        result_q, result_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [63:0]        arith_res;
    md_op_e             op;

    assign op = md_op_e'(bus.op_E);

    muldiv_arith u_arith (
        .op     (op),
        .a      (bus.srca_E),
        .b      (bus.srcb_E),
        .result (arith_res)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= 64'h0;
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Requests arriving while busy are dropped; the stall keeps them from
    // ever reaching E in that window.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_E) begin
                    result_d = arith_res;
                    if (op_is_div(op)) begin
                        state_d = ST_DIV;
                        cnt_d   = CNT_W'(DIV_LAT);
                    end else begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(MUL_LAT);
                    end
                end else begin
                    if (bus.mthi_E)
                        hi_d = bus.srca_E;
                    if (bus.mtlo_E)
                        lo_d = bus.srca_E;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = result_q[63:32];
                    lo_d    = result_q[31:0];
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.md_stall = bus.md_use_D & (bus.busy | bus.start_E);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency/busy window, stall, arithmetic
// corner cases, mthi/mtlo, and reset abort of an in-flight divide.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(
        .MUL_LAT (5),
        .DIV_LAT (10),
        .CNT_W   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requests must never reach E while the unit is busy.
    always @(negedge clk) begin
        if (reset && bus.busy && (bus.start_E || bus.mthi_E || bus.mtlo_E)) begin
            tests_failed++;
            $display("[TB] FAIL busy_request: request seen while busy at %0t", $time);
        end
    end

    task automatic idle_inputs();
        bus.start_E  = 1'b0;
        bus.op_E     = 2'b00;
        bus.mthi_E   = 1'b0;
        bus.mtlo_E   = 1'b0;
        bus.srca_E   = 32'h0;
        bus.srcb_E   = 32'h0;
        bus.md_use_D = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.md_stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: busy=%b hi=%h lo=%h stall=%b, want 0/0/0/0",
                     bus.busy, bus.hi, bus.lo, bus.md_stall);
        end
    endtask

    task automatic test_mthi_mtlo();
        @(posedge clk); #1;
        bus.mthi_E = 1'b1;
        bus.srca_E = 32'h0000_1234;
        @(posedge clk); #1;
        bus.mthi_E = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.hi !== 32'h0000_1234 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mthi: hi=%h lo=%h busy=%b, want 00001234/00000000/0",
                     bus.hi, bus.lo, bus.busy);
        end
        @(posedge clk); #1;
        bus.mtlo_E = 1'b1;
        bus.srca_E = 32'h0000_5678;
        @(posedge clk); #1;
        bus.mtlo_E = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.hi !== 32'h0000_1234 || bus.lo !== 32'h0000_5678 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mtlo: hi=%h lo=%h busy=%b, want 00001234/00005678/0",
                     bus.hi, bus.lo, bus.busy);
        end
    endtask

    // Issue one op in cycle t, check busy (and stall if md_use_D held) in
    // t+1..t+lat, then the committed result with busy low in t+lat+1.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic use_d);
        logic window_ok;
        @(posedge clk); #1;
        bus.start_E  = 1'b1;
        bus.op_E     = op;
        bus.srca_E   = a;
        bus.srcb_E   = b;
        bus.md_use_D = use_d;
        @(negedge clk);
        if (use_d) begin
            tests_run++;
            if (bus.md_stall !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL %s_issue_stall: md_stall=%b, want 1", name, bus.md_stall);
            end
        end
        @(posedge clk); #1;
        bus.start_E = 1'b0;
        bus.srca_E  = 32'hDEAD_BEEF;
        bus.srcb_E  = 32'h0BAD_F00D;
        window_ok   = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            if (bus.busy !== 1'b1 || (use_d && bus.md_stall !== 1'b1)) begin
                window_ok = 1'b0;
                $display("[TB] FAIL %s_busy_window: cycle t+%0d busy=%b stall=%b, want 1/%b",
                         name, k, bus.busy, bus.md_stall, use_d);
            end
        end
        tests_run++;
        if (!window_ok) tests_failed++;
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo || bus.md_stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s_result: busy=%b hi=%h lo=%h stall=%b, want 0/%h/%h/0",
                     name, bus.busy, bus.hi, bus.lo, bus.md_stall, exp_hi, exp_lo);
        end
        bus.md_use_D = 1'b0;
    endtask

    task automatic test_mult();
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 5,
               32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 5,
               32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    endtask

    task automatic test_div();
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b1);
        run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF, 1'b0);
        run_op("div_zero", MD_DIV, 32'hFFFF_FFFB, 32'd0, 10,
               32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'h0000_0000, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_stall_idle();
        @(posedge clk); #1;
        bus.md_use_D = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.md_stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_idle: md_stall=%b, want 0", bus.md_stall);
        end
        bus.md_use_D = 1'b0;
    endtask

    task automatic test_reset_abort();
        @(posedge clk); #1;
        bus.start_E = 1'b1;
        bus.op_E    = MD_DIVU;
        bus.srca_E  = 32'd100;
        bus.srcb_E  = 32'd7;
        @(posedge clk); #1;
        bus.start_E = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_abort: busy=%b hi=%h lo=%h, want 0/0/0",
                     bus.busy, bus.hi, bus.lo);
        end
        repeat (10) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_commit: busy=%b hi=%h lo=%h, want 0/0/0",
                     bus.busy, bus.hi, bus.lo);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        idle_inputs();
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_div();
        test_stall_idle();
        test_reset_abort();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequences the multi-cycle multiply/divide unit that sits beside the E-stage ALU and owns the HI/LO registers. Accepts mult/multu/div/divu, mthi and mtlo from the E stage, holds the result for a fixed latency, then commits it to HI/LO. Drives a stall request that the hazard unit ORs into stall_F, stall_D and flush_E whenever a D-stage instruction needs the unit while it is busy.

Parameters:
MUL_LAT, 5, cycles from accepted mult/multu to HI/LO commit (>=1)
DIV_LAT, 10, cycles from accepted div/divu to HI/LO commit (>=1)
CNT_W, 4, counter width; must hold max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
start_E  in  1  E-stage instruction is mult/multu/div/divu (already gated by flush_E)
op_E  in  2  00 mult, 01 multu, 10 div, 11 divu
mthi_E  in  1  E-stage mthi
mtlo_E  in  1  E-stage mtlo
srca_E  in  32  forwarded rs value
srcb_E  in  32  forwarded rt value
md_use_D  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  out  1  operation in flight
md_stall  out  1  stall request to hazard unit
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (reset==0 at posedge): state IDLE, counter 0, hi=0, lo=0, busy=0. Overrides any in-flight operation; no partial commit.
- States: IDLE, MUL, DIV.
- IDLE + start_E at posedge: latch operands and op; compute the product/quotient into an internal result register; counter <= MUL_LAT or DIV_LAT; go to MUL or DIV.
- MUL/DIV: counter decrements every cycle. When the counter is 1, commit result to hi/lo at that posedge and go to IDLE.
- Timing: start_E in cycle t -> busy=1 in cycles t+1..t+LAT; hi/lo show the new values and busy=0 from cycle t+LAT+1.
- busy is a registered output (state != IDLE).
- md_stall = md_use_D & (busy | start_E); combinational. start_E is included so a D-stage user directly behind an issuing op stalls.
- mthi_E/mtlo_E in IDLE: hi<=srca_E or lo<=srca_E at posedge. If asserted while busy, they are ignored; the stall rule guarantees this cannot occur. The testbench asserts this never happens.
- start_E while busy: ignored; same guarantee and same assertion.
- start_E together with mthi_E/mtlo_E: illegal; start_E wins.
- Arithmetic:
  - mult: signed 32x32 -> 64, {hi,lo}.
  - multu: unsigned 32x32 -> 64, {hi,lo}.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
- Divide by zero: lo=32'hFFFF_FFFF, hi=dividend (both div and divu). The result still takes DIV_LAT cycles.
- Signed overflow (div 32'h8000_0000 / 32'hFFFF_FFFF): lo=32'h8000_0000, hi=0.
- hi/lo are readable every cycle. mfhi/mflo are stalled in D while busy, so they never read a stale value.

Decomposition:
- Shared package/header: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), state encodings, default latencies.
- One sub-module, muldiv_arith: combinational 64-bit result from op, a, b, including the div-by-zero and overflow rules.
- muldiv_ctrl keeps the FSM, counter, result latch, HI/LO registers and stall logic.

Test Plan:
- Reset, then mult srca=32'hFFFF_FFFE (-2), srcb=3 at cycle t -> busy 1 for cycles t+1..t+5; at t+6 hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, busy=0.
- multu 32'hFFFF_FFFF x 2 -> hi=1, lo=32'hFFFF_FFFE after 5 cycles. md_use_D held at 1 -> md_stall=1 in cycles t..t+5, 0 at t+6.
- div -7/2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF after 10 cycles. divu 7/0 -> lo=32'hFFFF_FFFF, hi=7. div 32'h8000_0000/32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
- mthi srca=32'h1234 in IDLE -> hi=32'h1234 next cycle, lo unchanged, busy stays 0. mtlo likewise updates only lo.
- reset=0 asserted in cycle 3 of a div -> next cycle IDLE, busy=0, hi=lo=0. No commit occurs at the original completion cycle.
- start_E with md_use_D=1 in the same cycle -> md_stall=1 in that cycle. md_use_D=1 with busy=0 and start_E=0 -> md_stall=0.
